// File: rtl/dec_counter_pkg.sv
// ============================================================================
// Module   : dec_counter_pkg
// Purpose  : Shared width, constants and count type for the BCD decade counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_counter_pkg;

  localparam int COUNT_W = 4;

  typedef logic [COUNT_W-1:0] count_t;

  localparam count_t DEC_MAX  = 4'd9;
  localparam count_t DEC_ZERO = 4'd0;

endpackage : dec_counter_pkg

`default_nettype wire

// File: rtl/dec_counter_if.sv
// ============================================================================
// Module   : dec_counter_if
// Purpose  : Current/next count bundle between the count register and its
//            next-state logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dec_counter_if
  import dec_counter_pkg::*;
();

  count_t cur;
  count_t nxt;

  // Register side publishes the current count and consumes the next one.
  modport master (output cur, input nxt);
  modport slave  (input cur, output nxt);

endinterface : dec_counter_if

`default_nettype wire

// File: rtl/dec_counter_next.sv
// ============================================================================
// Module   : dec_counter_next
// Purpose  : Combinational next-state for the decade counter: increment,
//            wrap at MAX_COUNT and recovery of out-of-range values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_counter_next
  import dec_counter_pkg::*;
#(
  parameter count_t MAX_COUNT = DEC_MAX
) (
  dec_counter_if.slave nbus
);

  // Anything at or above the terminal value (including upset values) goes to 0.
  always_comb begin
    nbus.nxt = DEC_ZERO;
    if (nbus.cur < MAX_COUNT) begin
      nbus.nxt = nbus.cur + 4'd1;
    end
  end

endmodule : dec_counter_next

`default_nettype wire

// File: rtl/dec_counter.sv
// ============================================================================
// Module   : dec_counter
// Purpose  : Free-running BCD decade counter, async active-low reset.
//            Define DEC_COUNTER_TC_EN to add the p_tc terminal-count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_counter
  import dec_counter_pkg::*;
#(
  parameter count_t RESET_VALUE = DEC_ZERO,
  parameter count_t MAX_COUNT   = DEC_MAX
) (
  output count_t count,
  input  logic   p_clk_in,
  input  logic   p_rst
`ifdef DEC_COUNTER_TC_EN
  ,
  output logic   p_tc
`endif
);

  count_t count_q;
  count_t count_d;

  dec_counter_if nbus ();

  assign nbus.cur = count_q;
  assign count_d  = nbus.nxt;

  dec_counter_next #(
    .MAX_COUNT (MAX_COUNT)
  ) u_next (
    .nbus (nbus.slave)
  );

  always_ff @(posedge p_clk_in or negedge p_rst) begin
    if (!p_rst) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef DEC_COUNTER_TC_EN
  // Gated by p_rst so the flag drops the instant reset asserts.
  assign p_tc = p_rst & (count_q == MAX_COUNT);
`endif

endmodule : dec_counter

`default_nettype wire

// File: tb/tb_dec_counter.sv
// ============================================================================
// Module   : tb_dec_counter
// Purpose  : Directed self-checking bench for dec_counter (either build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_counter;
  import dec_counter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // bus.cur carries the DUT count; bus.nxt holds the bench's expected count.
  dec_counter_if bus ();

`ifdef DEC_COUNTER_TC_EN
  logic tc;
`endif

  dec_counter dut (
    .count    (bus.cur),
    .p_clk_in (clk),
    .p_rst    (rst_n)
`ifdef DEC_COUNTER_TC_EN
    ,
    .p_tc     (tc)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  // t=0..70: reset held, edges at 20 and 60 must not move the count.
  task automatic test_reset();
    int t_check[3];
    t_check = '{10, 20, 35};
    for (int i = 0; i < 3; i++) begin
      #(t_check[i]);
      bus.nxt = 4'd0;
      n_checks++;
      if (bus.cur !== bus.nxt)
        $display("FAIL reset_hold[%0d]: count=%b expected %b", i, bus.cur, bus.nxt);
      else
        n_pass++;
`ifdef DEC_COUNTER_TC_EN
      n_checks++;
      if (tc !== 1'b0)
        $display("FAIL reset_tc[%0d]: p_tc=%b expected 0", i, tc);
      else
        n_pass++;
`endif
    end
    #5 rst_n = 1'b1;  // t=70
  endtask

  // Edges at 100, 140, 180 advance 0 -> 1 -> 2 -> 3.
  task automatic test_count();
    int     t_step[4];
    count_t exp_v[4];
    t_step = '{20, 20, 40, 40};
    exp_v  = '{4'd0, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 4; i++) begin
      #(t_step[i]);
      bus.nxt = exp_v[i];
      n_checks++;
      if (bus.cur !== bus.nxt)
        $display("FAIL count_step[%0d]: count=%b expected %b", i, bus.cur, bus.nxt);
      else
        n_pass++;
    end
  endtask

  // Reset between edges (t=200) must clear immediately; the edge at 220 keeps 0.
  task automatic test_async_reset();
    #10 rst_n = 1'b0;
    #1;
    bus.nxt = 4'd0;
    n_checks++;
    if (bus.cur !== bus.nxt)
      $display("FAIL async_reset: count=%b expected %b", bus.cur, bus.nxt);
    else
      n_pass++;
`ifdef DEC_COUNTER_TC_EN
    n_checks++;
    if (tc !== 1'b0)
      $display("FAIL async_reset_tc: p_tc=%b expected 0", tc);
    else
      n_pass++;
`endif
    #29;
    n_checks++;
    if (bus.cur !== bus.nxt)
      $display("FAIL reset_edge: count=%b expected %b", bus.cur, bus.nxt);
    else
      n_pass++;
    #20 rst_n = 1'b1;  // t=250, between edges
  endtask

  // Twelve edges after release: 1..9, 0, 1, 2 with no 1010 in between.
  task automatic test_wrap();
    count_t exp_v[12];
    exp_v = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
              4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus.nxt = exp_v[i];
      n_checks++;
      if (bus.cur !== bus.nxt)
        $display("FAIL wrap_seq[%0d]: count=%b expected %b", i, bus.cur, bus.nxt);
      else
        n_pass++;
`ifdef DEC_COUNTER_TC_EN
      n_checks++;
      if (tc !== (exp_v[i] == 4'd9))
        $display("FAIL wrap_tc[%0d]: p_tc=%b expected %b", i, tc, (exp_v[i] == 4'd9));
      else
        n_pass++;
`endif
    end
  endtask

  // An upset value of 12 must recover to 0 on the next edge, then count on.
  task automatic test_illegal();
    count_t exp_v[2];
    exp_v = '{4'd0, 4'd1};
    @(negedge clk);
    force dut.count_q = 4'd12;
    #1;
    release dut.count_q;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      bus.nxt = exp_v[i];
      n_checks++;
      if (bus.cur !== bus.nxt)
        $display("FAIL illegal_recover[%0d]: count=%b expected %b", i, bus.cur, bus.nxt);
      else
        n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.nxt  = 4'd0;
    test_reset();
    test_count();
    test_async_reset();
    test_wrap();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dec_counter

`default_nettype wire
